// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor.
// Imported by serial_add_sub and digit_add_sub.
package serial_add_sub_pkg;

    localparam int unsigned StateWidth = 2;

    typedef enum logic [StateWidth-1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Bits needed to count n slices, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_add_sub.sv
// Combinational DIGIT-bit ripple slice: a + b + cin when sub=0, a - b - cin when sub=1.
// In subtract mode cin/c_out are an unsigned borrow, so slices chain directly.
module digit_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [DIGIT-1:0] s,
    output logic             c_out
);

    logic [DIGIT:0] chain;

    always_comb begin
        chain    = '0;
        s        = '0;
        chain[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = a[i] ^ b[i] ^ chain[i];
            if (sub) begin
                chain[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
            end else begin
                chain[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & chain[i]);
            end
        end
        c_out = chain[DIGIT];
    end

endmodule

// File: rtl/serial_add_sub.sv
// Digit-serial add/subtract: WIDTH/DIGIT slices processed LSB-first, one per clock.
// Define SERIAL_ADD_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_add_sub
    import serial_add_sub_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef SERIAL_ADD_SUB_OVF_EN
    output logic             c_out,
    output logic             ovf
`else
    output logic             c_out
`endif
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = cnt_width(N);

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_add_sub: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_add_sub: DIGIT must divide WIDTH and lie in 1..WIDTH");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [DIGIT-1:0] slice_s;
    logic             slice_c;
    logic [WIDTH-1:0] acc_next;
    logic             last_slice;

`ifdef SERIAL_ADD_SUB_OVF_EN
    // Operand sign bits are kept aside because the operand registers shift.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic ovf_q, ovf_d;
    logic ovf_calc;
`endif

    digit_add_sub #(
        .DIGIT (DIGIT)
    ) u_slice (
        .a     (a_q[DIGIT-1:0]),
        .b     (b_q[DIGIT-1:0]),
        .cin   (carry_q),
        .sub   (sub_q),
        .s     (slice_s),
        .c_out (slice_c)
    );

    // New slice enters at the top; after N shifts the first slice sits at bit 0.
    assign acc_next   = (acc_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
    assign last_slice = (cnt_q == CntW'(N - 1));

`ifdef SERIAL_ADD_SUB_OVF_EN
    always_comb begin
        ovf_calc = 1'b0;
        if (sub_q) begin
            ovf_calc = (a_msb_q != b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
        end else begin
            ovf_calc = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        result_d = result_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        c_out_d  = c_out_q;
        cnt_d    = cnt_q;
`ifdef SERIAL_ADD_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = cin;
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef SERIAL_ADD_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = slice_c;
                acc_d   = acc_next;
                cnt_d   = cnt_q + 1'b1;
                if (last_slice) begin
                    result_d = acc_next;
                    c_out_d  = slice_c;
`ifdef SERIAL_ADD_SUB_OVF_EN
                    ovf_d    = ovf_calc;
`endif
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            c_out_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            c_out_q  <= c_out_d;
            cnt_q    <= cnt_d;
        end
    end

`ifdef SERIAL_ADD_SUB_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);
    assign result = result_q;
    assign c_out  = c_out_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub: one DIGIT=1 and one DIGIT=4 instance, WIDTH=8.
// ovf is checked only when SERIAL_ADD_SUB_OVF_EN is defined.
module tb_serial_add_sub;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sel;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;

    logic       busy1, done1, co1;
    logic [7:0] res1;
    logic       busy4, done4, co4;
    logic [7:0] res4;
`ifdef SERIAL_ADD_SUB_OVF_EN
    logic       ovf1, ovf4;
`endif

    logic       o_busy, o_done, o_co;
    logic [7:0] o_res;

    int checks;
    int failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_add_sub #(
        .WIDTH (8),
        .DIGIT (1)
    ) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start & ~sel),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy1),
        .done   (done1),
        .result (res1),
`ifdef SERIAL_ADD_SUB_OVF_EN
        .c_out  (co1),
        .ovf    (ovf1)
`else
        .c_out  (co1)
`endif
    );

    serial_add_sub #(
        .WIDTH (8),
        .DIGIT (4)
    ) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start & sel),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy4),
        .done   (done4),
        .result (res4),
`ifdef SERIAL_ADD_SUB_OVF_EN
        .c_out  (co4),
        .ovf    (ovf4)
`else
        .c_out  (co4)
`endif
    );

    always_comb begin
        o_busy = sel ? busy4 : busy1;
        o_done = sel ? done4 : done1;
        o_co   = sel ? co4   : co1;
        o_res  = sel ? res4  : res1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation on the selected instance; latency counted from the start edge.
    task automatic do_op(input logic s, input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic op_sub, input logic op_cin, input int lat_exp,
                         input logic [7:0] res_exp, input logic co_exp, input logic ov_exp,
                         input string tag);
        int lat;
        sel   = s;
        a     = op_a;
        b     = op_b;
        sub   = op_sub;
        cin   = op_cin;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
        lat = 0;
        while (!o_done && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(lat_exp));
        check({tag, "_result"}, 32'(o_res), 32'(res_exp));
        check({tag, "_cout"}, 32'(o_co), 32'(co_exp));
`ifdef SERIAL_ADD_SUB_OVF_EN
        check({tag, "_ovf"}, 32'(sel ? ovf4 : ovf1), 32'(ov_exp));
`endif
        tick();
        check({tag, "_done_pulse"}, 32'(o_done), 32'd0);
        check({tag, "_hold"}, 32'(o_res), 32'(res_exp));
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        sel      = 1'b0;
        sub      = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;

        #2 rst_n = 1'b0;
        tick();
        tick();
        check("rst_result", 32'(res1), 32'd0);
        check("rst_cout", 32'(co1), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_done", 32'(done1), 32'd0);
        check("rst_result4", 32'(res4), 32'd0);
        rst_n = 1'b1;

        // DIGIT=1: N=8
        do_op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b0, 8, 8'h96, 1'b0, 1'b1, "add_5a_3c");
        do_op(1'b0, 8'h00, 8'h01, 1'b1, 1'b0, 8, 8'hFF, 1'b1, 1'b0, "sub_00_01");
        do_op(1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 8, 8'h00, 1'b1, 1'b0, "add_ff_cin");
        do_op(1'b0, 8'h10, 8'h01, 1'b1, 1'b1, 8, 8'h0E, 1'b0, 1'b0, "sub_10_01_bin");

        // DIGIT=4: N=2
        do_op(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 2, 8'h80, 1'b0, 1'b1, "d4_add_7f_01");

        // Start pulse in RUN must not disturb the operation in flight.
        sel   = 1'b1;
        a     = 8'h7F;
        b     = 8'h01;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        a     = 8'h00;
        b     = 8'h00;
        sub   = 1'b1;
        tick();
        start = 1'b0;
        check("midrun_busy", 32'(busy4), 32'd1);
        tick();
        check("midrun_done", 32'(done4), 32'd1);
        check("midrun_result", 32'(res4), 32'h80);
        check("midrun_cout", 32'(co4), 32'd0);
        tick();
        check("midrun_idle", 32'(busy4), 32'd0);

        // Asynchronous reset in the middle of a DIGIT=1 run.
        sel   = 1'b0;
        a     = 8'h5A;
        b     = 8'h3C;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #3 rst_n = 1'b0;
        #1;
        check("midrst_result", 32'(res1), 32'd0);
        check("midrst_cout", 32'(co1), 32'd0);
        check("midrst_busy", 32'(busy1), 32'd0);
        check("midrst_done", 32'(done1), 32'd0);
        tick();
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done1) pulses++;
        end
        check("midrst_no_done", 32'(pulses), 32'd0);
        do_op(1'b0, 8'h10, 8'h01, 1'b1, 1'b1, 8, 8'h0E, 1'b0, 1'b0, "after_rst");

        // Back-to-back: start held high through DONE.
        sel   = 1'b0;
        a     = 8'h01;
        b     = 8'h02;
        sub   = 1'b0;
        cin   = 1'b0;
        start = 1'b1;
        tick();
        a     = 8'h10;
        b     = 8'h20;
        lat   = 0;
        while (!done1 && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_lat1", 32'(lat), 32'd8);
        check("b2b_res1", 32'(res1), 32'h03);
        tick();
        start = 1'b0;
        check("b2b_rerun", 32'(busy1), 32'd1);
        check("b2b_hold_mid", 32'(res1), 32'h03);
        lat = 1;
        while (!done1 && lat < 40) begin
            tick();
            lat++;
        end
        check("b2b_period", 32'(lat), 32'd9);
        check("b2b_res2", 32'(res1), 32'h30);
        tick();
        check("b2b_end_idle", 32'(busy1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; legal values ≥2.
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per cycle; legal values 1..WIDTH, and WIDTH mod DIGIT = 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: request to capture operands and begin.
REQ-006 SHALL have port sub, input, 1 bit: 1 = subtract, 0 = add; captured with start.
REQ-007 SHALL have ports a and b, input, WIDTH bits each: operands; captured with start.
REQ-008 SHALL have port cin, input, 1 bit: carry-in (add) or borrow-in (sub); captured with start.
REQ-009 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-011 SHALL have port result, output, WIDTH bits: sum or difference.
REQ-012 SHALL have port c_out, output, 1 bit: carry-out (add) or borrow-out (sub).

Function
REQ-013 SHALL use three states: IDLE, RUN, DONE.
REQ-014 SHALL, in IDLE or DONE with start=1 at a rising edge, capture a, b, sub and cin, clear the digit counter, and enter RUN.
REQ-015 SHALL, in RUN, process one DIGIT-bit slice per edge, LSB slice first, with carry/borrow chained between slices in a register.
REQ-016 SHALL use N = WIDTH/DIGIT. Start is captured on edge 0; slices are processed on edges 1..N; DONE is entered on edge N. done is high for exactly one cycle, and busy is high from after edge 0 until edge N.
REQ-017 SHALL leave DONE for IDLE on the next edge when start=0, or re-enter RUN when start=1.
REQ-018 SHALL compute, for add: {c_out,result} = a + b + cin, modulo 2^(WIDTH+1).
REQ-019 SHALL compute, for sub: result = (a − b − cin) mod 2^WIDTH, and c_out = 1 iff a < b + cin (unsigned borrow).
REQ-020 SHALL update result and c_out only on the edge entering DONE, and hold them stable otherwise, including during the next RUN.
REQ-021 SHALL ignore start while in RUN; captured operands do not change mid-operation.
REQ-022 SHALL require DIGIT = WIDTH to give N = 1, i.e. a one-cycle RUN.

Reset
REQ-023 SHALL, on rst_n low at any time, including mid-RUN, immediately force state IDLE with busy=0, done=0, result=0, c_out=0, ovf=0 (if present), counter and carry cleared.
REQ-024 SHALL, after rst_n deasserts, accept start on the first rising edge.

Configuration
REQ-025 SHALL, when macro SERIAL_ADD_SUB_OVF_EN is defined, add output ovf (1 bit): signed two's-complement overflow of the operation. It updates and holds with result and resets to 0.
REQ-026 SHALL, when SERIAL_ADD_SUB_OVF_EN is undefined, omit the ovf port and its logic; all other behaviour is identical.

Structure
REQ-027 SHALL place the state enum typedef (IDLE/RUN/DONE) and the state-width constant in package serial_add_sub_pkg.
REQ-028 SHALL instantiate one combinational sub-module, digit_add_sub: a DIGIT-bit ripple slice with inputs a, b, cin and sub, and outputs s and c_out, using the same borrow semantics.

Verification
REQ-029 SHALL cover: WIDTH=8, DIGIT=1; a=0x5A, b=0x3C, sub=0, cin=0 → done 8 edges after start edge; result=0x96, c_out=0, ovf=1.
REQ-030 SHALL cover: a=0x00, b=0x01, sub=1, cin=0 → result=0xFF, c_out=1, ovf=0.
REQ-031 SHALL cover: a=0xFF, b=0x00, sub=0, cin=1 → result=0x00, c_out=1. Then a=0x10, b=0x01, sub=1, cin=1 → result=0x0E, c_out=0.
REQ-032 SHALL cover: WIDTH=8, DIGIT=4; a=0x7F, b=0x01, add → done 2 edges after start; result=0x80, ovf=1. A start pulse mid-RUN is ignored.
REQ-033 SHALL cover: rst_n low at edge 3 of RUN → outputs zero, busy=0, no done pulse. The next start completes normally.
REQ-034 SHALL cover: start held high through DONE → back-to-back operations. done pulses every N+1 cycles, and result holds between updates.
